// File: rtl/symbol_to_chip_if.sv
// symbol_to_chip_if: symbol handshake in, serial chip stream and status out
// master drives symbol/symbol_valid; slave (the spreader) drives symbol_ready,
// chip, chip_valid, sym_first, sym_last, busy and overflow.
interface symbol_to_chip_if;
  logic [3:0] symbol;
  logic       symbol_valid;
  logic       symbol_ready;
  logic       chip;
  logic       chip_valid;
  logic       sym_first;
  logic       sym_last;
  logic       busy;
  logic       overflow;
  modport master (
    output symbol, symbol_valid,
    input  symbol_ready, chip, chip_valid, sym_first, sym_last, busy, overflow
  );
  modport slave (
    input  symbol, symbol_valid,
    output symbol_ready, chip, chip_valid, sym_first, sym_last, busy, overflow
  );
endinterface

// File: rtl/symbol_to_chip.sv
// symbol_to_chip: 802.15.4 2.4 GHz DSSS spreader, 4-bit symbols to serial 32-chip PN words
// i_clk, i_rst_n (async, active-low); sif (slave): symbol handshake into a FIFO,
// chip stream with per-chip strobe and first/last markers, busy, sticky overflow.
module symbol_to_chip #(
  parameter int CLKS_PER_CHIP = 1,
  parameter int FIFO_DEPTH = 2
) (
  input logic i_clk,
  input logic i_rst_n,
  symbol_to_chip_if.slave sif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = CLKS_PER_CHIP > 1 ? $clog2(CLKS_PER_CHIP) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_CHIP - 1);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  // chip word per symbol, c0 in bit 31
  localparam logic [31:0] ROM [16] = '{
    32'hD9C3522E, 32'hED9C3522, 32'h2ED9C352, 32'h22ED9C35,
    32'h522ED9C3, 32'h3522ED9C, 32'hC3522ED9, 32'h9C3522ED,
    32'h8C96077B, 32'hB8C96077, 32'h7B8C9607, 32'h77B8C960,
    32'h077B8C96, 32'h6077B8C9, 32'h96077B8C, 32'hC96077B8
  };
  typedef enum logic {IDLE, SEND} state_t;
  state_t          state, state_n;
  logic [3:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_n;
  logic [31:0]     shreg, shreg_n;
  logic [DW-1:0]   div, div_n;
  logic [4:0]      cnt, cnt_n;
  logic            push, pop, wrap, done, chip_valid_n;

  assign sif.symbol_ready = count != FULL;
  assign push = sif.symbol_valid && sif.symbol_ready;
  assign wrap = state == SEND && div == DIV_LAST;
  assign done = wrap && cnt == 5'd31;
  // the end of c31 reloads straight from the FIFO, so back-to-back symbols have no gap
  assign pop = count != '0 && (state == IDLE || done);

  always_comb begin
    state_n = pop ? SEND : done ? IDLE : state;
    shreg_n = pop ? ROM[mem[rd_ptr]] : wrap ? {shreg[30:0], 1'b0} : shreg;
    div_n = pop || wrap || state == IDLE ? '0 : div + DW'(1);
    cnt_n = pop ? '0 : cnt + 5'(wrap);
    count_n = count + (AW+1)'(push) - (AW+1)'(pop);
    chip_valid_n = state_n == SEND && div_n == '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      shreg <= '0;
      div <= '0;
      cnt <= '0;
      sif.chip <= 1'b0;
      sif.chip_valid <= 1'b0;
      sif.sym_first <= 1'b0;
      sif.sym_last <= 1'b0;
      sif.busy <= 1'b0;
      sif.overflow <= 1'b0;
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count_n;
      shreg <= shreg_n;
      div <= div_n;
      cnt <= cnt_n;
      sif.chip <= state_n == SEND && shreg_n[31];
      sif.chip_valid <= chip_valid_n;
      sif.sym_first <= chip_valid_n && cnt_n == 5'd0;
      sif.sym_last <= chip_valid_n && cnt_n == 5'd31;
      sif.busy <= state_n == SEND || count_n != '0;
      sif.overflow <= sif.overflow || (sif.symbol_valid && !sif.symbol_ready);
    end
  end

  always_ff @(posedge i_clk) if (push) mem[wr_ptr] <= sif.symbol;
endmodule

// File: tb/tb_symbol_to_chip.sv
// tb_symbol_to_chip: directed and random checks of the spreader against an arithmetic PN model
module tb_symbol_to_chip;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  symbol_to_chip_if a ();
  symbol_to_chip_if b ();
  symbol_to_chip #(.CLKS_PER_CHIP(1), .FIFO_DEPTH(2)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .sif(a));
  symbol_to_chip #(.CLKS_PER_CHIP(4), .FIFO_DEPTH(2)) dut4 (.i_clk(clk), .i_rst_n(rst_n), .sif(b));

  int n_chk = 0, n_pass = 0, cyc = 0, first_pc = -1, busy_last = -1;
  logic a_chip [$], a_first [$], a_last [$];
  int a_cyc [$];
  logic [3:0] exp_q [$];
  logic b_cv [$], b_chip [$], b_busy [$];
  logic model_ovf = 1'b0, last_rdy;
  logic [31:0] w0;

  // seq(k): base word rotated right by 4*(k mod 8), odd chips inverted for k >= 8
  function automatic logic [31:0] seq(input logic [3:0] k);
    logic [63:0] d;
    d = {2{32'hD9C3522E}} >> (4 * k[2:0]);
    return k[3] ? d[31:0] ^ 32'h55555555 : d[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    if (a.chip_valid === 1'b1) begin
      a_chip.push_back(a.chip);
      a_first.push_back(a.sym_first);
      a_last.push_back(a.sym_last);
      a_cyc.push_back(cyc);
    end
    if (a.busy === 1'b1) busy_last = cyc;
    b_cv.push_back(b.chip_valid);
    b_chip.push_back(b.chip);
    b_busy.push_back(b.busy);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    a_chip.delete(); a_first.delete(); a_last.delete(); a_cyc.delete(); exp_q.delete();
    b_cv.delete(); b_chip.delete(); b_busy.delete();
    first_pc = -1;
    busy_last = -1;
  endtask

  task automatic drive(input logic v, input logic [3:0] s);
    a.symbol_valid = v;
    a.symbol = s;
    last_rdy = a.symbol_ready;
    if (v && last_rdy) begin
      if (first_pc < 0) first_pc = cyc;
      exp_q.push_back(s);
    end
    if (v && !last_rdy) model_ovf = 1'b1;
    step();
  endtask

  task automatic check_stream(input string tag, input bit contig);
    int n, ferr, lerr, gerr;
    logic [31:0] w;
    n = exp_q.size();
    ferr = 0; lerr = 0; gerr = 0;
    chk({tag, " len"}, a_chip.size(), 32 * n);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int j = 0; j < 32; j++) w = {w[30:0], (32*i+j < a_chip.size()) ? a_chip[32*i+j] : 1'bx};
      if (i == 0) w0 = w;
      chk({tag, " word"}, w, seq(exp_q[i]));
    end
    for (int i = 0; i < a_chip.size(); i++) begin
      if (a_first[i] !== (i % 32 == 0)) ferr++;
      if (a_last[i] !== (i % 32 == 31)) lerr++;
      if (a_cyc[i] != a_cyc[0] + i) gerr++;
    end
    chk({tag, " first"}, ferr, 0);
    chk({tag, " last"}, lerr, 0);
    if (contig) chk({tag, " gaps"}, gerr, 0);
    if (a_cyc.size() > 0) chk({tag, " latency"}, a_cyc[0] - first_pc, 2);
  endtask

  initial begin
    logic [3:0] r;
    logic [31:0] w8;
    int f, pulses, errs;
    a.symbol_valid = 1'b0; a.symbol = '0;
    b.symbol_valid = 1'b0; b.symbol = '0;
    #23;
    chk("reset a", {a.chip, a.chip_valid, a.sym_first, a.sym_last, a.busy, a.overflow, a.symbol_ready}, 7'b0000001);
    chk("reset b", {b.chip, b.chip_valid, b.sym_first, b.sym_last, b.busy, b.overflow, b.symbol_ready}, 7'b0000001);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single symbol 0
    clear();
    drive(1, 0);
    drive(0, 0);
    repeat (38) step();
    check_stream("sym0", 1);
    chk("sym0 busy end", busy_last, a_cyc[31]);
    chk("sym0 idle", {a.chip, a.chip_valid, a.busy}, 3'b000);
    // every symbol, one at a time
    for (int s = 0; s < 16; s++) begin
      clear();
      drive(1, 4'(s));
      drive(0, 0);
      repeat (34) step();
      check_stream($sformatf("sym%0d", s), 1);
      if (s == 1) chk("spot 1", w0, 32'hED9C3522);
      if (s == 8) chk("spot 8", w0, 32'h8C96077B);
      if (s == 15) chk("spot 15", w0, 32'hC96077B8);
    end
    // back-to-back 1 then 15
    clear();
    drive(1, 1);
    drive(1, 15);
    chk("b2b ready", last_rdy, 1);
    drive(0, 0);
    repeat (70) step();
    check_stream("b2b", 1);
    // four clocks per chip, symbol 8
    clear();
    b.symbol = 4'd8;
    b.symbol_valid = 1'b1;
    step();
    b.symbol_valid = 1'b0;
    repeat (140) step();
    w8 = seq(8);
    f = -1; pulses = 0; errs = 0;
    for (int i = 0; i < b_cv.size(); i++) if (b_cv[i] === 1'b1) begin
      pulses++;
      if (f < 0) f = i;
    end
    chk("c4 latency", f, 2);
    chk("c4 pulses", pulses, 32);
    for (int j = 0; j < 128; j++)
      if (f + j < b_cv.size() && (b_cv[f+j] !== (j % 4 == 0) || b_chip[f+j] !== w8[31 - j/4])) errs++;
    chk("c4 chips", errs, 0);
    chk("c4 busy", {b_busy[f+127], b_busy[f+128]}, 2'b10);
    // overflow with continuous valid
    clear();
    chk("ovf clear", a.overflow, 0);
    drive(1, 3); r[3] = last_rdy;
    drive(1, 4); r[2] = last_rdy;
    drive(1, 5); r[1] = last_rdy;
    drive(1, 6); r[0] = last_rdy;
    drive(0, 0);
    chk("ovf ready seq", r, 4'b1110);
    repeat (110) step();
    check_stream("ovf", 1);
    chk("ovf flag", a.overflow, model_ovf);
    // reset during chip 10 of the second symbol with one more queued
    clear();
    drive(1, 1);
    drive(1, 2);
    drive(1, 3);
    drive(0, 0);
    for (int k = 0; k < 200 && a_chip.size() < 42; k++) step();
    chk("rst reach", a_chip.size(), 42);
    rst_n = 1'b0;
    model_ovf = 1'b0;
    #1;
    chk("rst outs", {a.chip, a.chip_valid, a.sym_first, a.sym_last, a.busy, a.overflow, a.symbol_ready}, 7'b0000001);
    @(posedge clk);
    #2 rst_n = 1'b1;
    clear();
    repeat (10) step();
    chk("rst no resume", a_chip.size(), 0);
    chk("rst idle", busy_last, -1);
    clear();
    drive(1, 7);
    drive(0, 0);
    repeat (34) step();
    check_stream("rst sym7", 1);
    chk("spot 7", w0, 32'h9C3522ED);
    // random traffic
    clear();
    for (int k = 0; k < 400; k++) drive($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)));
    drive(0, 0);
    for (int k = 0; k < 3000 && a.busy; k++) step();
    chk("rand drain", a.busy, 0);
    check_stream("rand", 0);
    chk("rand ovf", a.overflow, model_ovf);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
